string_hw_avalon: RTL and testbench

STRING_HW_AVALON -- requirements
Module: string_hw_avalon

---
 rtl/string_hw_avalon.sv | 144 ++++++++++++++
 tb/tb_string_hw_avalon.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/string_hw_avalon.sv
// Avalon-MM string coprocessor: two string operands in word registers, a
// single-cycle compare/case-convert/reverse engine, and a control word.
module string_hw_avalon #(
    parameter int MAX_BLOCKS   = 2,
    parameter int ADDRESS_BITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    chipselect,
    input  logic                    read,
    input  logic                    write,
    input  logic [ADDRESS_BITS:0]   address,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata
);

    localparam int NB = 4 * MAX_BLOCKS;
    localparam int AW = ADDRESS_BITS + 1;
    localparam int W  = 32 * MAX_BLOCKS;

    logic [31:0]  a [MAX_BLOCKS];
    logic [31:0]  b [MAX_BLOCKS];
    logic         go;
    logic         done;
    logic [2:0]   idx;

    logic [W-1:0] a_flat;
    logic [W-1:0] b_flat;
    logic [W-1:0] r_flat;
    logic         equal;
    logic         found;
    logic         wr;
    logic         start;
    logic [31:0]  rd;

    assign wr    = chipselect && write;
    assign start = go && !done;

    // Byte 0 (first character) sits in the top byte of the flattened operand.
    always_comb begin
        logic [7:0] ab;
        logic [7:0] bb;
        a_flat = '0;
        b_flat = '0;
        ab     = '0;
        bb     = '0;
        for (int k = 0; k < MAX_BLOCKS; k++) begin
            a_flat[32*(MAX_BLOCKS-1-k) +: 32] = a[k];
            b_flat[32*(MAX_BLOCKS-1-k) +: 32] = b[k];
        end

        found = 1'b0;
        equal = 1'b1;
        for (int i = 0; i < NB; i++) begin
            ab = a_flat[8*(NB-1-i) +: 8];
            bb = b_flat[8*(NB-1-i) +: 8];
            if (!found) begin
                if (ab != bb) begin
                    equal = 1'b0;
                    found = 1'b1;
                end else if (ab == 8'h00) begin
                    found = 1'b1;
                end
            end
        end

        r_flat = a_flat;
        case (idx)
            3'd0: begin
                r_flat    = '0;
                r_flat[0] = equal;
            end
            3'd1: begin
                for (int i = 0; i < NB; i++) begin
                    ab = a_flat[8*i +: 8];
                    if (ab >= 8'h61 && ab <= 8'h7a)
                        r_flat[8*i +: 8] = ab - 8'h20;
                end
            end
            3'd2: begin
                for (int i = 0; i < NB; i++) begin
                    ab = a_flat[8*i +: 8];
                    if (ab >= 8'h41 && ab <= 8'h5a)
                        r_flat[8*i +: 8] = ab + 8'h20;
                end
            end
            3'd3: begin
                for (int i = 0; i < NB; i++)
                    r_flat[8*(NB-1-i) +: 8] = a_flat[8*i +: 8];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < MAX_BLOCKS; k++) begin
                a[k] <= '0;
                b[k] <= '0;
            end
            go   <= 1'b0;
            done <= 1'b0;
            idx  <= '0;
        end else begin
            if (wr) begin
                if (address == '0) begin
                    go  <= writedata[1];
                    idx <= writedata[4:2];
                end
                for (int k = 0; k < MAX_BLOCKS; k++) begin
                    // A host write to A loses against a result landing on the same edge.
                    if (!start && address == AW'(k + 1))
                        a[k] <= writedata;
                    if (address == AW'(k + 1 + MAX_BLOCKS))
                        b[k] <= writedata;
                end
            end
            if (start) begin
                for (int k = 0; k < MAX_BLOCKS; k++)
                    a[k] <= r_flat[32*(MAX_BLOCKS-1-k) +: 32];
                done <= 1'b1;
            end
            if (wr && address == '0 && !writedata[1])
                done <= 1'b0;
        end
    end

    always_comb begin
        rd = '0;
        if (reset && chipselect && read) begin
            if (address == '0)
                rd = {27'b0, idx, go, done};
            for (int k = 0; k < MAX_BLOCKS; k++) begin
                if (address == AW'(k + 1))
                    rd = a[k];
                if (address == AW'(k + 1 + MAX_BLOCKS))
                    rd = b[k];
            end
        end
    end

    assign readdata = rd;

endmodule

// File: tb/tb_string_hw_avalon.sv
// Directed bench for string_hw_avalon; reads push expected words into a
// queue that a negedge monitor pops and compares against readdata.
module tb_string_hw_avalon;

    logic        clk;
    logic        reset;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [4:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    string_hw_avalon #(.MAX_BLOCKS(2), .ADDRESS_BITS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .read       (read),
        .write      (write),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every read strobe is one presented response.
    always @(negedge clk) begin
        if (read) begin
            logic [31:0] e;
            string       n;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read: readdata=%h with no expected entry", readdata);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (readdata !== e) begin
                    errors++;
                    $display("FAIL %s: readdata=%h expected=%h", n, readdata, e);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_write(input logic [4:0] adr, input logic [31:0] data);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = adr;
        writedata  = data;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write      = 1'b0;
        writedata  = '0;
    endtask

    task automatic do_read(input logic [4:0] adr, input logic [31:0] e, input string n, input logic cs = 1'b1);
        exp_q.push_back(e);
        name_q.push_back(n);
        chipselect = cs;
        read       = 1'b1;
        address    = adr;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        read       = 1'b0;
    endtask

    task automatic write_a(input logic [31:0] w0, input logic [31:0] w1);
        do_write(5'd1, w0);
        do_write(5'd2, w1);
    endtask

    task automatic check_a(input logic [31:0] e0, input logic [31:0] e1, input string n);
        do_read(5'd1, e0, {n, "_a0"});
        do_read(5'd2, e1, {n, "_a1"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        address    = '0;
        writedata  = '0;
        idle(2);
        do_read(5'd0, 32'h0, "in_reset_ctrl");
        reset = 1'b1;
        idle(1);
        do_read(5'd0, 32'h0, "rst_ctrl");
        do_read(5'd1, 32'h0, "rst_a0");
        do_read(5'd4, 32'h0, "rst_b1");

        // Equal strings
        write_a(32'h61626364, 32'h65666768);
        do_write(5'd3, 32'h61626364);
        do_write(5'd4, 32'h65666768);
        do_write(5'd0, 32'h02);
        idle(1);
        check_a(32'h0, 32'h1, "cmp_eq");
        do_read(5'd0, 32'h03, "cmp_eq_ctrl");
        do_read(5'd3, 32'h61626364, "cmp_b0_kept");
        do_read(5'd4, 32'h65666768, "cmp_b1_kept");

        // Differ in second word
        do_write(5'd0, 32'h00);
        write_a(32'h61626364, 32'h65666768);
        do_write(5'd4, 32'h61626364);
        do_write(5'd0, 32'h02);
        idle(1);
        check_a(32'h0, 32'h0, "cmp_ne");
        do_read(5'd0, 32'h03, "cmp_ne_ctrl");

        // Leading NUL terminates compare early
        do_write(5'd0, 32'h00);
        do_read(5'd0, 32'h00, "ctrl_cleared");
        do_write(5'd1, 32'h00616263);
        do_write(5'd3, 32'h00616263);
        do_write(5'd0, 32'h02);
        idle(1);
        check_a(32'h0, 32'h1, "cmp_nul");

        // To-upper / to-lower
        do_write(5'd0, 32'h00);
        write_a(32'h41624364, 32'h45662020);
        do_write(5'd0, 32'h06);
        idle(1);
        check_a(32'h41424344, 32'h45462020, "upper");
        do_write(5'd0, 32'h00);
        write_a(32'h41624364, 32'h45202020);
        do_write(5'd0, 32'h0A);
        idle(1);
        check_a(32'h61626364, 32'h65202020, "lower");
        do_read(5'd0, 32'h0B, "lower_ctrl");

        // Reverse held two cycles applies once; reapply restores
        do_write(5'd0, 32'h00);
        write_a(32'h48656C6C, 32'h6F212020);
        do_write(5'd0, 32'h0E);
        idle(2);
        check_a(32'h2020216F, 32'h6C6C6548, "rev1");
        do_write(5'd0, 32'h00);
        do_write(5'd0, 32'h0E);
        idle(2);
        check_a(32'h48656C6C, 32'h6F212020, "rev2");

        // Unused index leaves A alone but still sets done
        do_write(5'd0, 32'h00);
        do_write(5'd0, 32'h16);
        idle(1);
        check_a(32'h48656C6C, 32'h6F212020, "idx5");
        do_read(5'd0, 32'h17, "idx5_ctrl");

        // Host write to A on the compute edge loses to the result
        do_write(5'd0, 32'h00);
        write_a(32'h61626364, 32'h65666768);
        do_write(5'd0, 32'h06);
        do_write(5'd1, 32'h11111111);
        idle(1);
        check_a(32'h41424344, 32'h45464748, "collide");

        // Out-of-range address and deselected read
        do_write(5'd5, 32'hDEADBEEF);
        do_read(5'd5, 32'h0, "oor_5");
        do_read(5'd31, 32'h0, "oor_31");
        do_read(5'd1, 32'h0, "no_cs", 1'b0);

        // Reset in the middle of a pending operation
        do_write(5'd0, 32'h00);
        write_a(32'h61626364, 32'h65666768);
        do_write(5'd3, 32'h12345678);
        do_write(5'd0, 32'h0E);
        reset = 1'b0;
        do_read(5'd1, 32'h0, "mid_rst_a0");
        #3;
        reset = 1'b1;
        idle(1);
        for (int i = 0; i < 5; i++)
            do_read(5'(i), 32'h0, $sformatf("post_rst_%0d", i));
        idle(2);
        do_read(5'd1, 32'h0, "post_rst_no_compute");

        idle(3);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
